prog_load_ctrl: RTL
===================

# prog_load_ctrl

Program-load sequencer and memory arbiter for the RIDECORE top level. After reset it accepts a byte stream, the output of the UART receiver, and writes instruction lines into `imem_ld` and data words into `dmem`. It owns the address/data/write-enable muxes in front of both memories and holds the `pipeline` core in reset until loading completes. It then hands both memory ports to the core for the rest of the run.

## Interface
- `ADDR_LEN`, 32: core address width.
- `IMEM_LINES`, 512: imem depth in 128-bit lines; `imem_addr` is log2 of this, 9 bits.
- `DMEM_WORDS`, 1024: dmem depth in 32-bit words.
- `clk`  in  1  single clock for all state.
- `reset_x`  in  1  reset, synchronous, active-low.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  received byte.
- `rx_ready`  out  1  byte accepted this cycle when `rx_valid & rx_ready`.
- `core_pc`  in  ADDR_LEN  core fetch PC.
- `core_dmem_addr`, `core_dmem_wdata`, `core_dmem_we`  in  ADDR_LEN/32/1  core data port.
- `dmem_addr`, `dmem_wdata`, `dmem_we`  out  ADDR_LEN/32/1  to dmem, byte address.
- `imem_addr`  out  9  imem line index.
- `imem_wdata`  out  128  imem write line.
- `imem_we`  out  1  imem write strobe.
- `prog_loading`  out  1  loader owns the memories.
- `core_reset`  out  1  active-high reset to `pipeline`.
- `load_err`  out  1  header length out of range; sticky until reset.

## Operation
- Stream format, little-endian: 4-byte imem line count NI, then NI×16 bytes of imem, then 4-byte dmem word count ND, then ND×4 bytes of dmem. Loading starts at address 0 for both memories.
- States: `HDR_I`, `LD_I`, `HDR_D`, `LD_D`, `RUN`, `ERR`. After reset the FSM is in `HDR_I`.
- `HDR_I`: collects 4 bytes into NI.
  - NI=0 → `HDR_D`.
  - NI>IMEM_LINES → `ERR`.
  - Otherwise → `LD_I`.
- `LD_I`: bytes assemble into a 32-bit word, byte 0 at bits [7:0]. Each completed word shifts into `line[127:96]` and older words move down 32 bits, so the first word of a line ends at [31:0].
  - On the 16th byte of a line: `imem_we` is pulsed, the line index increments, and the byte counter clears.
  - After line NI → `HDR_D`.
- `HDR_D`: same as `HDR_I`, but the limit is DMEM_WORDS. ND=0 → `RUN`.
- `LD_D`: on every 4th byte, `dmem_we` is pulsed with the assembled word at byte address `4×index`. After word ND → `RUN`.
- `RUN` is terminal until reset. `ERR` is terminal until reset; the core stays in reset and `load_err`=1.
- `rx_ready` = 1 in `HDR_*` and `LD_*`, 0 in `RUN` and `ERR`. A cycle with no byte holds all state.
- `prog_loading` = 1 in every state except `RUN`.
- Mux when `prog_loading`=1: dmem and imem are driven from the loader. Loader `dmem_we`/`imem_we` are 0 except on write pulses.
- Mux when `prog_loading`=0: `dmem_*` = `core_dmem_*` and `imem_addr` = `core_pc[12:4]`. `imem_we`=0 and `imem_wdata`=0.
- `core_reset` = `prog_loading` registered once, so the core leaves reset one cycle after the memories switch to it.
- Counters are 32-bit for NI/ND and never wrap. The range check happens before any memory write.

## Timing
- Reset values:
  - State `HDR_I`; all counters and `line` are 0.
  - `prog_loading`=1, `core_reset`=1, `rx_ready`=1.
  - `imem_we`=0, `dmem_we`=0, `load_err`=0.
  - `imem_addr`=0, `dmem_addr`=0, `imem_wdata`=0, `dmem_wdata`=0.
- Loader write strobes, addresses and data are registered. They are valid for exactly one cycle, the cycle after the completing byte is accepted.
- Last byte accepted at cycle T:
  - State is `RUN` at T+1 and `prog_loading` falls at T+1.
  - The last write strobe is also at T+1 and is still routed from the loader.
  - `core_reset` falls at T+2.
- `reset_x` low mid-load: all state returns to reset values on the next edge. Partial words and lines are discarded, and memory writes already done are not undone.
- Max throughput is 1 byte per cycle, with no stall between a header and data.

## Test plan
- NI=1, ND=1, bytes 00..0F of line, dmem word 0xDEADBEEF.
  - → one `imem_we` with `imem_addr`=0 and `imem_wdata`=0x0F0E0D0C_0B0A0908_07060504_03020100.
  - → one `dmem_we` with `dmem_addr`=0 and `dmem_wdata`=0xDEADBEEF.
  - → `core_reset` falls 2 cycles after the last byte.
- NI=0, ND=0 (8 header bytes only) → no writes; `RUN` after the 8th byte; core muxed in with `imem_addr`=`core_pc[12:4]`.
- NI=513 → `ERR`; `load_err`=1; `rx_ready`=0; no `imem_we`; `core_reset` stays 1 for 100 cycles.
- NI=2 with `rx_valid` toggling every other cycle → exactly 2 `imem_we` pulses at lines 0 and 1 with correct data; no write on idle cycles.
- `reset_x` low for 1 cycle after byte 10 of line 0, then a full NI=1/ND=0 stream → a single `imem_we` carrying only the new bytes.
- After `RUN`: drive `core_dmem_we`=1, addr 0x40, data 0x12345678 → same-cycle `dmem_we`=1, `dmem_addr`=0x40, `dmem_wdata`=0x12345678; further `rx_valid` is ignored.

Source files
------------

// File: rtl/prog_load_ctrl.sv
// Program-load sequencer: streams UART bytes into imem/dmem, then
// hands both memory ports to the core and releases its reset.
module prog_load_ctrl #(
  parameter int ADDR_LEN   = 32,
  parameter int IMEM_LINES = 512,
  parameter int DMEM_WORDS = 1024,
  localparam int IA        = $clog2(IMEM_LINES)
) (
  input  logic                clk,
  input  logic                reset_x,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                rx_ready,
  input  logic [ADDR_LEN-1:0] core_pc,
  input  logic [ADDR_LEN-1:0] core_dmem_addr,
  input  logic [31:0]         core_dmem_wdata,
  input  logic                core_dmem_we,
  output logic [ADDR_LEN-1:0] dmem_addr,
  output logic [31:0]         dmem_wdata,
  output logic                dmem_we,
  output logic [IA-1:0]       imem_addr,
  output logic [127:0]        imem_wdata,
  output logic                imem_we,
  output logic                prog_loading,
  output logic                core_reset,
  output logic                load_err
);

  typedef enum logic [2:0] {
    HDR_I, LD_I, HDR_D, LD_D, RUN, ERR
  } state_t;

  state_t              state;
  logic [3:0]          bcnt;
  logic [31:0]         word;
  logic [127:0]        line;
  logic [31:0]         cnt;
  logic [31:0]         idx;

  logic [IA-1:0]       ld_imem_addr;
  logic [127:0]        ld_imem_wdata;
  logic                ld_imem_we;
  logic [ADDR_LEN-1:0] ld_dmem_addr;
  logic [31:0]         ld_dmem_wdata;
  logic                ld_dmem_we;

  logic [31:0]  word_nx;
  logic [127:0] line_nx;
  logic [31:0]  idx_nx;
  logic         take;
  logic         dsel;
  logic         isel;
  logic         unused_pc;

  assign word_nx = {rx_data, word[31:8]};
  assign line_nx = {word_nx, line[127:32]};
  assign idx_nx  = idx + 32'd1;

  assign rx_ready     = (state != RUN) && (state != ERR);
  assign prog_loading = (state != RUN);
  assign load_err     = (state == ERR);
  assign take         = rx_valid & rx_ready;

  always_ff @(posedge clk) begin
    if (!reset_x) begin
      state         <= HDR_I;
      bcnt          <= '0;
      word          <= '0;
      line          <= '0;
      cnt           <= '0;
      idx           <= '0;
      ld_imem_addr  <= '0;
      ld_imem_wdata <= '0;
      ld_imem_we    <= 1'b0;
      ld_dmem_addr  <= '0;
      ld_dmem_wdata <= '0;
      ld_dmem_we    <= 1'b0;
      core_reset    <= 1'b1;
    end else begin
      ld_imem_we <= 1'b0;
      ld_dmem_we <= 1'b0;
      core_reset <= prog_loading;
      if (take) begin
        word <= word_nx;
        bcnt <= bcnt + 4'd1;
        case (state)
          HDR_I: if (bcnt[1:0] == 2'd3) begin
            bcnt <= '0;
            cnt  <= word_nx;
            idx  <= '0;
            if (word_nx == 32'd0)
              state <= HDR_D;
            else if (word_nx > 32'(IMEM_LINES))
              state <= ERR;
            else
              state <= LD_I;
          end
          LD_I: begin
            if (bcnt[1:0] == 2'd3)
              line <= line_nx;
            // Last byte of a line: line_nx already holds all 4 words
            if (bcnt == 4'd15) begin
              ld_imem_we    <= 1'b1;
              ld_imem_addr  <= idx[IA-1:0];
              ld_imem_wdata <= line_nx;
              idx           <= idx_nx;
              if (idx_nx == cnt)
                state <= HDR_D;
            end
          end
          HDR_D: if (bcnt[1:0] == 2'd3) begin
            bcnt <= '0;
            cnt  <= word_nx;
            idx  <= '0;
            if (word_nx == 32'd0)
              state <= RUN;
            else if (word_nx > 32'(DMEM_WORDS))
              state <= ERR;
            else
              state <= LD_D;
          end
          LD_D: if (bcnt[1:0] == 2'd3) begin
            bcnt          <= '0;
            ld_dmem_we    <= 1'b1;
            ld_dmem_addr  <= ADDR_LEN'(idx << 2);
            ld_dmem_wdata <= word_nx;
            idx           <= idx_nx;
            if (idx_nx == cnt)
              state <= RUN;
          end
          default: ;
        endcase
      end
    end
  end

  // The final loader write lands the cycle RUN begins; keep it routed
  assign dsel = prog_loading | ld_dmem_we;
  assign isel = prog_loading | ld_imem_we;

  assign dmem_addr  = dsel ? ld_dmem_addr  : core_dmem_addr;
  assign dmem_wdata = dsel ? ld_dmem_wdata : core_dmem_wdata;
  assign dmem_we    = dsel ? ld_dmem_we    : core_dmem_we;
  assign imem_addr  = isel ? ld_imem_addr  : core_pc[IA+3:4];
  assign imem_wdata = isel ? ld_imem_wdata : '0;
  assign imem_we    = ld_imem_we;

  assign unused_pc = ^{core_pc[ADDR_LEN-1:IA+4], core_pc[3:0]};

endmodule
